// File: rtl/fric_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fric_pkg: FRIC opcodes, idle byte and sequencer state encodings.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package fric_pkg;

    localparam logic [3:0] FRIC_WR_REQ = 4'h2;
    localparam logic [3:0] FRIC_RD_REQ = 4'h3;
    localparam logic [3:0] FRIC_WR_ACK = 4'h4;
    localparam logic [3:0] FRIC_RD_ACK = 4'h5;
    localparam logic [7:0] FRIC_IDLE   = 8'h00;

    typedef logic [2:0] tx_state_t;
    localparam tx_state_t TX_IDLE = 3'd0;
    localparam tx_state_t TX_HDR  = 3'd1;
    localparam tx_state_t TX_ADR  = 3'd2;
    localparam tx_state_t TX_DA0  = 3'd3;
    localparam tx_state_t TX_DA1  = 3'd4;

    typedef logic [2:0] rx_state_t;
    localparam rx_state_t RX_IDLE = 3'd0;
    localparam rx_state_t RX_HDR  = 3'd1;
    localparam rx_state_t RX_ADR  = 3'd2;
    localparam rx_state_t RX_DA0  = 3'd3;
    localparam rx_state_t RX_DA1  = 3'd4;
    localparam rx_state_t RX_DONE = 3'd5;

    function automatic logic [7:0] fric_hdr(input logic [3:0] op, input logic [3:0] port);
        return {op, port};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fric_client_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fric_client_master_if: requester handshake plus FRIC byte streams.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface fric_client_master_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [3:0]  req_port;
    logic [7:0]  req_addr;
    logic [15:0] req_wdat;
    logic        rsp_valid;
    logic [15:0] rsp_rdat;
    logic        rsp_err;
    logic [7:0]  fric_out;
    logic [7:0]  fric_in;

    modport master (
        input  req_valid, req_wr, req_port, req_addr, req_wdat, fric_in,
        output req_ready, rsp_valid, rsp_rdat, rsp_err, fric_out
    );

    modport slave (
        output req_valid, req_wr, req_port, req_addr, req_wdat, fric_in,
        input  req_ready, rsp_valid, rsp_rdat, rsp_err, fric_out
    );

endinterface
`default_nettype wire

// File: rtl/fric_reply_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fric_reply_parser: registers fric_in and decodes the slave reply.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fric_reply_parser
    import fric_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        wr,
    input  logic [3:0]  port,
    input  logic [7:0]  addr,
    input  logic        tmo_hit,
    input  logic [7:0]  fric_in,
    output logic        rx_idle,
    output logic        rx_done,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdat,
    output logic        rsp_err
);

    logic [7:0]  r_fric_inr;
    rx_state_t   r_state;
    rx_state_t   w_next;
    logic        r_err;
    logic [15:0] r_rdat;
    logic [7:0]  w_exp_hdr;

    assign w_exp_hdr = fric_hdr(wr ? FRIC_WR_ACK : FRIC_RD_ACK, port);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fric_inr <= FRIC_IDLE;
        end else begin
            r_fric_inr <= fric_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE: if (start) w_next = RX_HDR;
            RX_HDR: begin
                if (r_fric_inr == w_exp_hdr) begin
                    w_next = RX_ADR;
                end else if (r_fric_inr != FRIC_IDLE) begin
                    w_next = RX_DONE;
                end
            end
            RX_ADR:  w_next = wr ? RX_DONE : RX_DA0;
            RX_DA0:  w_next = RX_DA1;
            RX_DA1:  w_next = RX_DONE;
            RX_DONE: w_next = RX_IDLE;
            default: w_next = RX_IDLE;
        endcase
        if (tmo_hit && (r_state != RX_IDLE) && (r_state != RX_DONE)) begin
            w_next = RX_DONE;
        end
    end

    // Error and data accumulate over the reply; a timeout discards any captured data.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_err  <= 1'b0;
            r_rdat <= 16'h0000;
        end else if (tmo_hit && (r_state != RX_IDLE) && (r_state != RX_DONE)) begin
            r_err  <= 1'b1;
            r_rdat <= 16'h0000;
        end else begin
            case (r_state)
                RX_HDR: begin
                    if ((r_fric_inr != FRIC_IDLE) && (r_fric_inr != w_exp_hdr)) r_err <= 1'b1;
                end
                RX_ADR: begin
                    if (r_fric_inr != addr) r_err <= 1'b1;
                end
                RX_DA0:  r_rdat[7:0]  <= r_fric_inr;
                RX_DA1:  r_rdat[15:8] <= r_fric_inr;
                default: ;
            endcase
        end
    end

    always_comb begin
        rx_idle   = (r_state == RX_IDLE);
        rx_done   = (r_state == RX_DONE);
        rsp_valid = rx_done;
        rsp_rdat  = rx_done ? r_rdat : 16'h0000;
        rsp_err   = rx_done ? r_err : 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/fric_client_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fric_client_master: serialises one request onto FRIC, awaits reply.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fric_client_master
    import fric_pkg::*;
#(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    fric_client_master_if.master bus
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic        w_accept;
    logic        r_wr;
    logic [3:0]  r_port;
    logic [7:0]  r_addr;
    logic [15:0] r_wdat;
    tx_state_t   r_tx_state;
    tx_state_t   w_tx_next;
    logic [7:0]  w_fric_out_next;
    logic [7:0]  r_fric_out;
    logic [7:0]  r_tmo_cnt;
    logic        w_tmo_hit;
    logic        w_rx_idle;
    logic        w_rx_done;
    logic        w_rsp_valid;
    logic [15:0] w_rsp_rdat;
    logic        w_rsp_err;

    assign bus.req_ready = !rst && w_rx_idle;
    assign w_accept      = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr   <= 1'b0;
            r_port <= 4'h0;
            r_addr <= 8'h00;
            r_wdat <= 16'h0000;
        end else if (w_accept) begin
            r_wr   <= bus.req_wr;
            r_port <= bus.req_port;
            r_addr <= bus.req_addr;
            r_wdat <= bus.req_wdat;
        end
    end

    // Loaded with 1 on acceptance so the count equals cycles elapsed since acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= 8'd0;
        end else if (w_accept) begin
            r_tmo_cnt <= 8'd1;
        end else if (!w_rx_idle && (r_tmo_cnt != 8'hFF)) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end

    assign w_tmo_hit = !w_rx_idle && !w_rx_done && (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
        end else begin
            r_tx_state <= w_tx_next;
        end
    end

    always_comb begin
        w_tx_next = r_tx_state;
        if (w_rx_done || w_tmo_hit) begin
            w_tx_next = TX_IDLE;
        end else begin
            case (r_tx_state)
                TX_IDLE: if (w_accept) w_tx_next = TX_HDR;
                TX_HDR:  w_tx_next = TX_ADR;
                TX_ADR:  w_tx_next = r_wr ? TX_DA0 : TX_IDLE;
                TX_DA0:  w_tx_next = TX_DA1;
                TX_DA1:  w_tx_next = TX_IDLE;
                default: w_tx_next = TX_IDLE;
            endcase
        end
    end

    // The header is only entered from acceptance, so it is built from the live request.
    always_comb begin
        w_fric_out_next = FRIC_IDLE;
        case (w_tx_next)
            TX_HDR:  w_fric_out_next = fric_hdr(bus.req_wr ? FRIC_WR_REQ : FRIC_RD_REQ,
                                                bus.req_port);
            TX_ADR:  w_fric_out_next = r_addr;
            TX_DA0:  w_fric_out_next = r_wdat[7:0];
            TX_DA1:  w_fric_out_next = r_wdat[15:8];
            default: w_fric_out_next = FRIC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fric_out <= FRIC_IDLE;
        end else begin
            r_fric_out <= w_fric_out_next;
        end
    end

    assign bus.fric_out = r_fric_out;

    fric_reply_parser u_parser (
        .clk       (clk),
        .rst       (rst),
        .start     (w_accept),
        .wr        (r_wr),
        .port      (r_port),
        .addr      (r_addr),
        .tmo_hit   (w_tmo_hit),
        .fric_in   (bus.fric_in),
        .rx_idle   (w_rx_idle),
        .rx_done   (w_rx_done),
        .rsp_valid (w_rsp_valid),
        .rsp_rdat  (w_rsp_rdat),
        .rsp_err   (w_rsp_err)
    );

    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdat  = w_rsp_rdat;
    assign bus.rsp_err   = w_rsp_err;

endmodule
`default_nettype wire
